// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access controller.
// State encoding, exception codes and load-mode codes used by
// mem_access_ctrl and mem_access_check.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  localparam logic [1:0] LM_WORD    = 2'b00;
  localparam logic [1:0] LM_HALF_S  = 2'b01;
  localparam logic [1:0] LM_HALF_U  = 2'b10;
  localparam logic [1:0] LM_ILLEGAL = 2'b11;

  // Stores always move a full word; loads are word-sized only in LM_WORD.
  function automatic logic is_word_access(input logic read, input logic [1:0] load_mode);
    return (!read) || (load_mode == LM_WORD);
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for one memory request.
// Priority: illegal encoding, then misalignment, then address range.
// The misalignment check only exists when MEM_ACCESS_ALIGN_CHECK_EN is defined;
// otherwise unaligned accesses are treated as legal.
module mem_access_check
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_MAX = 3999
) (
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  load_mode,
  input  logic [31:0] addr,
  output logic [1:0]  exc_code
);

  localparam logic [32:0] ADDR_MAX_EXT = 33'(ADDR_MAX);

  logic        word_s;
  logic [32:0] last_byte_s;
  logic        misalign_s;
  logic        range_s;
  logic        illegal_s;

  // Classify the request; the range compare is 33 bits so the top of the
  // address space cannot wrap back into range.
  always_comb begin
    word_s      = is_word_access(read, load_mode);
    last_byte_s = {1'b0, addr} + (word_s ? 33'd3 : 33'd1);
    range_s     = (last_byte_s > ADDR_MAX_EXT);
    illegal_s   = (read && write) || (read && (load_mode == LM_ILLEGAL));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign_s  = word_s ? (addr[1:0] != 2'b00) : addr[0];
`else
    misalign_s  = 1'b0;
`endif
    if (illegal_s) begin
      exc_code = EXC_ILLEGAL;
    end else if (misalign_s) begin
      exc_code = EXC_MISALIGN;
    end else if (range_s) begin
      exc_code = EXC_RANGE;
    end else begin
      exc_code = EXC_NONE;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle access controller between EX/MEM and the data memory.
// A legal request holds the memory strobe for MEM_LATENCY cycles, then spends
// one DONE cycle presenting the registered result; an illegal request spends
// one ERR cycle pulsing the exception. stall is the only combinational output.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (enables misalignment check).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_MAX    = 3999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_load_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [1:0]  dm_load_mode,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic [1:0]  load_mode_r;
  logic [31:0] address_r;
  logic [31:0] write_data_r;
  logic        resp_valid_r;
  logic [31:0] resp_data_r;
  logic        exc_valid_r;
  logic [1:0]  exc_code_r;
  logic        accept_s;
  logic [1:0]  chk_code_s;
  logic        stall_s;

  mem_access_check #(
    .ADDR_MAX (ADDR_MAX)
  ) u_check (
    .read      (req_read),
    .write     (req_write),
    .load_mode (req_load_mode),
    .addr      (req_addr),
    .exc_code  (chk_code_s)
  );

  // A request is taken only in IDLE and only if it actually reads or writes.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req_valid && (req_read || req_write);
  end

  // Pipeline freeze: while accepting and for the whole strobe window.
  always_comb begin
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else if (state_r == ST_ACCESS) begin
      stall_s = 1'b1;
    end else if (accept_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Access FSM with registered memory strobes, response and exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      load_mode_r  <= 2'b00;
      address_r    <= 32'd0;
      write_data_r <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      exc_valid_r  <= 1'b0;
      exc_code_r   <= EXC_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (chk_code_s == EXC_NONE) begin
              state_r      <= ST_ACCESS;
              cnt_r        <= CNT_INIT;
              mem_read_r   <= req_read;
              mem_write_r  <= req_write;
              load_mode_r  <= req_load_mode;
              address_r    <= req_addr;
              write_data_r <= req_wdata;
            end else begin
              state_r     <= ST_ERR;
              exc_valid_r <= 1'b1;
              exc_code_r  <= chk_code_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == 4'd0) begin
            state_r      <= ST_DONE;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            if (mem_read_r) begin
              resp_data_r <= dm_read_data;
            end else begin
              resp_data_r <= resp_data_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          resp_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        ST_ERR: begin
          exc_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_read_r   <= 1'b0;
          mem_write_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          exc_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dm_mem_read   = mem_read_r;
  assign dm_mem_write  = mem_write_r;
  assign dm_load_mode  = load_mode_r;
  assign dm_address    = address_r;
  assign dm_write_data = write_data_r;
  assign stall         = stall_s;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = resp_data_r;
  assign exc_valid     = exc_valid_r;
  assign exc_code      = exc_code_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a big-endian byte memory model.
// Expected responses are queued when a request is driven and compared when
// resp_valid or exc_valid is seen.
module tb_mem_access_ctrl;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_load_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [1:0]  dm_load_mode;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        exc_valid;
  logic [1:0]  exc_code;

  mem_access_ctrl #(
    .MEM_LATENCY (LAT),
    .ADDR_MAX    (3999)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_load_mode (req_load_mode),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .dm_mem_read   (dm_mem_read),
    .dm_mem_write  (dm_mem_write),
    .dm_load_mode  (dm_load_mode),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory, big-endian
  logic [7:0]  mem [0:4095];
  logic        mem_clear;
  logic [11:0] ra;
  logic [31:0] rword;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (dm_mem_write) begin
      mem[dm_address[11:0]]         <= dm_write_data[31:24];
      mem[dm_address[11:0] + 12'd1] <= dm_write_data[23:16];
      mem[dm_address[11:0] + 12'd2] <= dm_write_data[15:8];
      mem[dm_address[11:0] + 12'd3] <= dm_write_data[7:0];
    end
  end

  always_comb begin
    ra    = dm_address[11:0];
    rword = {mem[ra], mem[ra + 12'd1], mem[ra + 12'd2], mem[ra + 12'd3]};
    case (dm_load_mode)
      2'b01:   dm_read_data = {{16{rword[31]}}, rword[31:16]};
      2'b10:   dm_read_data = {16'h0000, rword[31:16]};
      default: dm_read_data = rword;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_data = 32'd0;

  // Scoreboard: compare every response/exception against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (resp_valid || exc_valid)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("exc_valid", {31'd0, exc_valid}, {31'd0, e.err});
        check_eq("resp_valid", {31'd0, resp_valid}, {31'd0, !e.err});
        if (e.err) check_eq("exc_code", {30'd0, exc_code}, {30'd0, e.code});
        else       check_eq("resp_data", resp_data, e.data);
      end
    end
  end

  // Drive one request at posedge+1 and follow it until the pipeline is free again
  task automatic issue(input logic rd, input logic wr, input logic [1:0] lm,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] ecode, input logic [31:0] edata);
    exp_t e;
    int   n;
    int   strobes;
    int   stalls;
    e.err  = (ecode != 2'b00);
    e.code = ecode;
    e.data = edata;
    if (!e.err) begin
      if (rd) last_data = edata;
      else    e.data = last_data;
    end
    sb_q.push_back(e);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_load_mode = lm; req_addr = addr; req_wdata = wdata;
    #1;
    check_eq("stall_accept", {31'd0, stall}, 32'd1);
    strobes = 0;
    stalls  = 1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    n = 0;
    while (!(resp_valid || exc_valid) && n < 40) begin
      if (dm_mem_read || dm_mem_write) strobes++;
      if (stall) stalls++;
      @(posedge clk); #1;
      n++;
    end
    check_eq("resp_timeout", {31'd0, (n < 40)}, 32'd1);
    check_eq("strobe_cycles", strobes, e.err ? 32'd0 : LAT);
    check_eq("stall_cycles", stalls, e.err ? 32'd1 : LAT + 1);
    check_eq("stall_final", {31'd0, stall}, 32'd0);
    check_eq("strobe_final", {30'd0, dm_mem_read, dm_mem_write}, 32'd0);
    @(posedge clk); #1;
    check_eq("pulse_width", {30'd0, resp_valid, exc_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_unaligned_code;
  logic [1:0] exp_3997_code;

  initial begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    exp_unaligned_code = 2'b01;
    exp_3997_code      = 2'b01;
`else
    exp_unaligned_code = 2'b00;
    exp_3997_code      = 2'b10;
`endif
    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_load_mode = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_strobes", {30'd0, dm_mem_read, dm_mem_write}, 32'd0);
    check_eq("rst_addr", dm_address, 32'd0);
    check_eq("rst_wdata", dm_write_data, 32'd0);
    check_eq("rst_resp", {29'd0, resp_valid, exc_valid, stall}, 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_mode_code", {28'd0, dm_load_mode, exc_code}, 32'd0);
    mem_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 2'b00, 32'd0);
    issue(1'b1, 1'b0, 2'b00, 32'h10, 32'd0, 2'b00, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 2'b00, 32'hFFFFDEAD);
    issue(1'b1, 1'b0, 2'b10, 32'h10, 32'd0, 2'b00, 32'h0000DEAD);
    issue(1'b1, 1'b0, 2'b00, 32'h12, 32'd0, exp_unaligned_code, 32'hBEEF0000);
    issue(1'b1, 1'b0, 2'b00, 32'd3997, 32'd0, exp_3997_code, 32'd0);
    issue(1'b1, 1'b0, 2'b00, 32'd4000, 32'd0, 2'b10, 32'd0);
    issue(1'b1, 1'b0, 2'b00, 32'hFFFFFFFC, 32'd0, 2'b10, 32'd0);
    issue(1'b0, 1'b1, 2'b00, 32'd3996, 32'h12345678, 2'b00, 32'd0);
    issue(1'b1, 1'b0, 2'b10, 32'd3998, 32'd0, 2'b00, 32'h00005678);
    issue(1'b1, 1'b1, 2'b00, 32'h10, 32'd0, 2'b11, 32'd0);
    issue(1'b1, 1'b0, 2'b11, 32'h10, 32'd0, 2'b11, 32'd0);

    // req_valid with neither read nor write is ignored
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h10;
    #1;
    check_eq("nop_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_eq("nop_quiet", {28'd0, dm_mem_read, dm_mem_write, stall, resp_valid}, 32'd0);
    req_valid = 1'b0;

    // Reset in the middle of an access
    req_valid = 1'b1; req_read = 1'b1; req_load_mode = 2'b00; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0;
    check_eq("mid_strobe", {31'd0, dm_mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_drop", {29'd0, dm_mem_read, stall, resp_valid}, 32'd0);
    check_eq("mid_rst_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_data = 32'd0;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 2'b00, 32'h10, 32'd0, 2'b00, 32'hDEADBEEF);

    // Back-to-back stores then a load of the same word
    issue(1'b0, 1'b1, 2'b00, 32'h20, 32'h11111111, 2'b00, 32'd0);
    issue(1'b0, 1'b1, 2'b00, 32'h20, 32'h22222222, 2'b00, 32'd0);
    issue(1'b1, 1'b0, 2'b00, 32'h20, 32'd0, 2'b00, 32'h22222222);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
